rng_scheduler: RTL and testbench
================================

# rng_scheduler

Sequencing and sharing controller for the 32-bit LFSR random-number generator in the RSA datapath. It loads the LFSR seed, runs the shift register long enough to produce a fresh 32-bit word, and hands each word to exactly one of N_REQ requesters using round-robin arbitration. Typical requesters are the prime-candidate generator and the blinding/exponent logic.

## Interface
- N_REQ, 2, number of requesters (≥2)
- SHIFTS, 32, LFSR enable cycles between delivered words (≥1); one full word turnover at 32
- SEED_DEFAULT, 32'hACE1_2468, non-zero seed substituted when a zero seed is supplied
- clk  input  1  system clock, all logic on posedge
- rst  input  1  asynchronous, active-low reset
- reseed  input  1  single-cycle pulse: load `seed` and restart word generation
- seed  input  32  seed value sampled when `reseed`=1
- lfsr_acquire_seed  output  1  to LFSR, loads `lfsr_seed`
- lfsr_seed  output  32  to LFSR, registered seed (zero replaced by SEED_DEFAULT)
- lfsr_en  output  1  to LFSR, advance one step
- lfsr_out  input  32  from LFSR, current register contents
- req  input  N_REQ  level request per requester, held until granted
- gnt  output  N_REQ  one-hot grant, one-cycle pulse, coincident with rnd_valid
- rnd_valid  output  1  one-cycle pulse: rnd_data valid for the granted requester
- rnd_data  output  32  delivered random word, held until the next delivery
- busy  output  1  high in SEED and FILL

## Operation
- States: UNSEEDED, SEED, FILL, READY.
- UNSEEDED (after reset): no LFSR activity. Requests stay pending and receive no grant.
- `reseed` in any state → SEED on the next edge. Register lfsr_seed = (seed==0 ? SEED_DEFAULT : seed).
- SEED (1 cycle): lfsr_acquire_seed=1, lfsr_en=0. Load fill counter with SHIFTS. Next state FILL.
- FILL: lfsr_en=1 every cycle and the counter decrements. When the counter reaches 1, go to READY on the next edge. FILL therefore lasts exactly SHIFTS cycles.
- READY: lfsr_en=0.
  - If any req bit is set, the round-robin arbiter picks the first set bit at or after pointer `rr`, wrapping at N_REQ.
  - On the next edge: gnt[k]=1, rnd_valid=1, rnd_data=lfsr_out, rr=(k+1) mod N_REQ, counter=SHIFTS, state=FILL.
  - Each word is delivered at most once. A word is never given to two requesters.
- Requester protocol:
  - req[k] stays high until gnt[k] is seen. The requester deasserts in the cycle after gnt and may reassert later.
  - A req that drops before its grant is simply not served. No error is raised.
- `reseed` coincident with a READY grant decision: reseed wins. No grant, no rnd_valid, state=SEED. Pending requests remain pending.
- `reseed` during FILL aborts the fill. The counter is reloaded after SEED.
- Reset mid-operation: immediate return to UNSEEDED with all outputs at reset values. rr=0.
- Reset values: gnt=0, rnd_valid=0, rnd_data=0, lfsr_acquire_seed=0, lfsr_en=0, lfsr_seed=0, busy=0.
- All outputs are registered. lfsr_en and lfsr_acquire_seed are decoded from registered state only.

## Timing
- Reseed pulse at edge t:
  - lfsr_acquire_seed high in cycle t+1.
  - lfsr_en high in cycles t+2 … t+1+SHIFTS.
  - READY from cycle t+2+SHIFTS.
- Grant latency: req visible in READY cycle c → gnt/rnd_valid/rnd_data in cycle c+1. lfsr_en is high from c+1 for SHIFTS cycles.
- Max throughput: one word per SHIFTS+1 cycles. Continuous request at SHIFTS=32 gives one word every 33 cycles.
- Two requesters both held high are served alternately 0,1,0,1… starting from rr.
- rnd_data changes only in cycles where rnd_valid=1.

## Test plan
- Reset then idle 100 cycles with req=2'b11 → no gnt, lfsr_en=0, lfsr_acquire_seed=0, busy=0.
- reseed with seed=32'h1234_5678 at cycle t → lfsr_seed=32'h1234_5678, acquire pulse at t+1, exactly 32 lfsr_en cycles, busy falls at t+34. With req0 held, gnt=2'b01 at t+35 and rnd_data equals the model LFSR value after 32 steps.
- seed=0 → lfsr_seed=32'hACE1_2468. Words delivered match the reference model seeded with 32'hACE1_2468.
- req=2'b11 held continuously after seeding → grants 01,10,01,10 spaced 33 cycles apart, gnt never two-hot, every rnd_data distinct and model-correct.
- reseed pulsed 10 cycles into FILL → fill restarts with 32 full lfsr_en cycles after the new acquire pulse. The pending request is served once, with a word from the new seed.
- rst asserted during FILL with req0 high, then released and reseeded → all outputs 0 during reset. The first grant after reseed goes to requester 0 (rr reset).

Source files
------------

// File: rtl/rng_scheduler.sv
// rng_scheduler: seeds the 32-bit LFSR, runs it SHIFTS steps per word and
// hands each fresh word to one requester picked round-robin.
// Ports:
//   clk, rst          clock, async active-low reset
//   reseed, seed      one-cycle reseed pulse and seed value
//   lfsr_acquire_seed load strobe to the LFSR
//   lfsr_seed         registered seed (zero replaced by SEED_DEFAULT)
//   lfsr_en           LFSR step enable
//   lfsr_out          current LFSR contents
//   req, gnt          level requests, one-hot grant pulse
//   rnd_valid         word delivery pulse, coincident with gnt
//   rnd_data          last delivered word
//   busy              high while seeding or filling
module rng_scheduler #(
   parameter int          N_REQ        = 2,
   parameter int          SHIFTS       = 32,
   parameter logic [31:0] SEED_DEFAULT = 32'hACE1_2468
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             reseed,
   input  logic [31:0]      seed,
   output logic             lfsr_acquire_seed,
   output logic [31:0]      lfsr_seed,
   output logic             lfsr_en,
   input  logic [31:0]      lfsr_out,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic             rnd_valid,
   output logic [31:0]      rnd_data,
   output logic             busy
);

   localparam int CW = $clog2(SHIFTS + 1);
   localparam int PW = $clog2(N_REQ);

   localparam logic [1:0] S_UNSEEDED = 2'd0;
   localparam logic [1:0] S_SEED     = 2'd1;
   localparam logic [1:0] S_FILL     = 2'd2;
   localparam logic [1:0] S_READY    = 2'd3;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [PW-1:0] rr;

   logic          found;
   logic [PW-1:0] pick;
   logic [PW-1:0] rr_next;
   logic [PW:0]   sum;

   // Scan requesters starting at rr, wrapping at N_REQ; first hit wins.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      sum   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sum = {1'b0, rr} + (PW+1)'(i);
         if (sum >= (PW+1)'(N_REQ))
            sum = sum - (PW+1)'(N_REQ);
         if (!found && req[sum[PW-1:0]]) begin
            found = 1'b1;
            pick  = sum[PW-1:0];
         end
      end
   end

   always_comb begin
      if (pick == PW'(N_REQ - 1))
         rr_next = '0;
      else
         rr_next = pick + PW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_UNSEEDED;
         cnt       <= '0;
         rr        <= '0;
         lfsr_seed <= '0;
         gnt       <= '0;
         rnd_valid <= 1'b0;
         rnd_data  <= '0;
      end else begin
         gnt       <= '0;
         rnd_valid <= 1'b0;
         // Reseed overrides everything, including a pending grant.
         if (reseed) begin
            state     <= S_SEED;
            lfsr_seed <= (seed == 32'd0) ? SEED_DEFAULT : seed;
         end else begin
            unique case (state)
               S_SEED: begin
                  state <= S_FILL;
                  cnt   <= CW'(SHIFTS);
               end
               S_FILL: begin
                  cnt <= cnt - CW'(1);
                  if (cnt == CW'(1))
                     state <= S_READY;
               end
               S_READY: begin
                  if (found) begin
                     gnt       <= N_REQ'(1) << pick;
                     rnd_valid <= 1'b1;
                     rnd_data  <= lfsr_out;
                     rr        <= rr_next;
                     cnt       <= CW'(SHIFTS);
                     state     <= S_FILL;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign lfsr_acquire_seed = (state == S_SEED);
   assign lfsr_en           = (state == S_FILL);
   assign busy              = lfsr_acquire_seed | lfsr_en;

endmodule

// File: tb/tb_rng_scheduler.sv
// tb_rng_scheduler: bench for rng_scheduler with an LFSR stand-in,
// directed sequences, a seed table and a cycle-window reference model.
module tb_rng_scheduler;

   localparam int          N   = 2;
   localparam int          SH  = 32;
   localparam logic [31:0] DEF = 32'hACE1_2468;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          reseed = 1'b0;
   logic [31:0]   seed = '0;
   logic [N-1:0]  req = '0;
   logic          acq, en, valid, busy;
   logic [31:0]   lseed, data, lfsr_out;
   logic [N-1:0]  gnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rng_scheduler #(.N_REQ(N), .SHIFTS(SH), .SEED_DEFAULT(DEF)) dut (
      .clk(clk),
      .rst(rst),
      .reseed(reseed),
      .seed(seed),
      .lfsr_acquire_seed(acq),
      .lfsr_seed(lseed),
      .lfsr_en(en),
      .lfsr_out(lfsr_out),
      .req(req),
      .gnt(gnt),
      .rnd_valid(valid),
      .rnd_data(data),
      .busy(busy)
   );

   function automatic logic [31:0] step(input logic [31:0] v);
      return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
   endfunction

   function automatic logic [31:0] stepn(input logic [31:0] v, input int n);
      logic [31:0] r;
      r = v;
      for (int i = 0; i < n; i++) r = step(r);
      return r;
   endfunction

   // LFSR stand-in driven by the DUT's control outputs
   logic [31:0] lreg = '0;
   assign lfsr_out = lreg;
   always @(posedge clk) begin
      if (acq) lreg <= lseed;
      else if (en) lreg <= step(lreg);
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Reference model: absolute cycle windows for acquire/fill/ready,
   // words computed as seed stepped SH*(k+1) times.
   int          cyc = 0;
   bit          m_seeded = 0;
   int          acq_c = -1, flo = -1, fhi = -2, rdy = 0, nw = 0, m_rr = 0;
   logic [31:0] m_seed = '0, m_data = '0;

   always begin : model
      logic          s_rst, s_rs;
      logic [31:0]   s_seed;
      logic [N-1:0]  s_req, e_gnt;
      logic          e_val, e_acq, e_en;
      bit            was_ready;
      int            k;
      @(posedge clk);
      s_rst = rst; s_rs = reseed; s_seed = seed; s_req = req;
      was_ready = m_seeded && (cyc >= rdy);
      cyc++;
      e_gnt = '0; e_val = 1'b0;
      if (!s_rst) begin
         m_seeded = 0; m_rr = 0; m_seed = '0; m_data = '0; nw = 0;
      end else if (s_rs) begin
         m_seed   = (s_seed == 0) ? DEF : s_seed;
         m_seeded = 1;
         nw       = 0;
         acq_c    = cyc;
         flo      = cyc + 1;
         fhi      = cyc + SH;
         rdy      = cyc + 1 + SH;
      end else if (was_ready && s_req != 0) begin
         k = -1;
         for (int i = 0; i < N; i++)
            if (k < 0 && s_req[(m_rr + i) % N]) k = (m_rr + i) % N;
         e_gnt  = N'(1) << k;
         e_val  = 1'b1;
         m_data = stepn(m_seed, SH * (nw + 1));
         nw++;
         m_rr = (k + 1) % N;
         flo  = cyc;
         fhi  = cyc + SH - 1;
         rdy  = cyc + SH;
      end
      e_acq = m_seeded && (cyc == acq_c);
      e_en  = m_seeded && (cyc >= flo) && (cyc <= fhi);
      #1;
      chk("m_gnt",   32'(gnt),   32'(e_gnt));
      chk("m_valid", 32'(valid), 32'(e_val));
      chk("m_data",  data,       m_data);
      chk("m_acq",   32'(acq),   32'(e_acq));
      chk("m_en",    32'(en),    32'(e_en));
      chk("m_busy",  32'(busy),  32'(e_acq | e_en));
      chk("m_seed",  lseed,      m_seed);
   end

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reseed(input logic [31:0] s);
      seed   = s;
      reseed = 1'b1;
      @(negedge clk);
      reseed = 1'b0;
   endtask

   task automatic wait_gnt(input int limit, output int w,
                           output logic [N-1:0] g);
      w = 0;
      g = '0;
      while (w < limit && g == 0) begin
         @(negedge clk);
         w++;
         g = gnt;
      end
      chk("gnt_seen", 32'(g != 0), 32'd1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_gnt"},   32'(gnt),   0);
      chk({tag, "_valid"}, 32'(valid), 0);
      chk({tag, "_data"},  data,       0);
      chk({tag, "_acq"},   32'(acq),   0);
      chk({tag, "_en"},    32'(en),    0);
      chk({tag, "_seed"},  lseed,      0);
      chk({tag, "_busy"},  32'(busy),  0);
   endtask

   typedef struct {
      logic [31:0] seed;
      logic [31:0] exp_seed;
   } vec_t;

   initial begin
      vec_t         tbl[4];
      int           ng, ne, na, nb, w;
      logic [N-1:0] g;
      logic [31:0]  prev;

      tbl[0] = '{32'h0000_0000, DEF};
      tbl[1] = '{32'h0000_0001, 32'h0000_0001};
      tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
      tbl[3] = '{32'h8000_0000, 32'h8000_0000};

      // reset, then idle unseeded with both requests up
      nclk(3);
      chk_zero("rst0");
      rst = 1'b1;
      req = 2'b11;
      ng = 0; ne = 0; na = 0; nb = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         ng += int'(gnt != 0); ne += int'(en);
         na += int'(acq);      nb += int'(busy);
      end
      chk("idle_gnt", ng, 0);
      chk("idle_en",  ne, 0);
      chk("idle_acq", na, 0);
      chk("idle_busy", nb, 0);

      // seed timing with req0 held
      req = 2'b01;
      pulse_reseed(32'h1234_5678);
      chk("s2_acq",  32'(acq), 1);
      chk("s2_en0",  32'(en),  0);
      chk("s2_seed", lseed, 32'h1234_5678);
      ne = 0; nb = 0;
      for (int i = 0; i < SH; i++) begin
         @(negedge clk);
         ne += int'(en); nb += int'(busy);
      end
      chk("s2_en_cnt",   ne, SH);
      chk("s2_busy_cnt", nb, SH);
      @(negedge clk);
      chk("s2_busy_rdy", 32'(busy), 0);
      chk("s2_en_rdy",   32'(en),   0);
      chk("s2_gnt_rdy",  32'(gnt),  0);
      @(negedge clk);
      chk("s2_gnt",   32'(gnt),   32'b01);
      chk("s2_valid", 32'(valid), 1);
      chk("s2_data",  data, stepn(32'h1234_5678, SH));
      req = '0;

      // seed table, including the zero-seed substitution
      foreach (tbl[i]) begin
         pulse_reseed(tbl[i].seed);
         chk("tbl_acq",  32'(acq), 1);
         chk("tbl_seed", lseed, tbl[i].exp_seed);
         req = 2'b11;
         wait_gnt(60, w, g);
         chk("tbl_lat",    w, SH + 2);
         chk("tbl_onehot", $countones(g), 1);
         chk("tbl_data",   data, stepn(tbl[i].exp_seed, SH));
         req = '0;
      end

      // reseed ten cycles into a fill
      req = 2'b01;
      pulse_reseed(32'hDEAD_BEEF);
      nclk(10);
      chk("s5_en_mid", 32'(en), 1);
      pulse_reseed(32'h0BAD_F00D);
      chk("s5_acq", 32'(acq), 1);
      chk("s5_en0", 32'(en),  0);
      ne = 0;
      for (int i = 0; i < SH; i++) begin
         @(negedge clk);
         ne += int'(en);
      end
      chk("s5_en_cnt", ne, SH);
      wait_gnt(5, w, g);
      chk("s5_lat",  w, 2);
      chk("s5_gnt",  32'(g), 32'b01);
      chk("s5_data", data, stepn(32'h0BAD_F00D, SH));
      req = '0;
      ng = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         ng += int'(gnt != 0);
      end
      chk("s5_once", ng, 0);

      // reset during fill; rr was 1 and must return to 0
      req = 2'b01;
      pulse_reseed(32'h5555_AAAA);
      nclk(5);
      rst = 1'b0;
      #1;
      chk_zero("rst1");
      nclk(3);
      chk_zero("rst2");
      rst = 1'b1;
      req = 2'b11;
      pulse_reseed(32'h1357_9BDF);
      wait_gnt(40, w, g);
      chk("s6_gnt",  32'(g), 32'b01);
      chk("s6_data", data, stepn(32'h1357_9BDF, SH));
      req = '0;

      // both requesters held: alternate 01,10,01,10 every SH+1 cycles
      rst = 1'b0;
      nclk(2);
      rst = 1'b1;
      req = 2'b11;
      pulse_reseed(32'hC0FF_EE00);
      prev = data;
      for (int i = 0; i < 4; i++) begin
         wait_gnt(40, w, g);
         if (i > 0) chk("s4_space", w, SH + 1);
         chk("s4_gnt", 32'(g), (i % 2 == 0) ? 32'b01 : 32'b10);
         chk("s4_data", data, stepn(32'hC0FF_EE00, SH * (i + 1)));
         chk("s4_distinct", 32'(data != prev), 1);
         prev = data;
      end
      req = '0;

      // random traffic checked by the model
      pulse_reseed($urandom);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         for (int k = 0; k < N; k++) begin
            if (gnt[k]) req[k] = 1'b0;
            else if (!req[k] && $urandom_range(0, 19) == 0) req[k] = 1'b1;
            else if (req[k] && $urandom_range(0, 199) == 0) req[k] = 1'b0;
         end
         reseed = ($urandom_range(0, 299) == 0);
         seed   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         rst    = !($urandom_range(0, 1499) == 0);
      end
      rst = 1'b1;
      reseed = 1'b0;
      nclk(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
